// File: rtl/parc_mem_arbiter.sv
// parc_mem_arbiter: merges the PARCv2 core's imem and dmem request ports onto
// one shared memory port and steers the in-order responses back using a
// small tag FIFO (tag 1 = dmem, 0 = imem).
// Optional build macro PARC_MEM_ARB_RR_EN selects round-robin grant on
// contention; undefined gives fixed dmem-over-imem priority.
module parc_mem_arbiter #(
  parameter int p_depth    = 4,
  parameter int p_ptr_bits = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] imemreq_msg,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  output logic [34:0] imemresp_msg,
  output logic        imemresp_val,
  input  logic [66:0] dmemreq_msg,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  output logic [34:0] dmemresp_msg,
  output logic        dmemresp_val,
  output logic [66:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic [34:0] memresp_msg,
  input  logic        memresp_val,
  output logic        resp_err
);

  localparam logic [p_ptr_bits:0] DEPTH_C = (p_ptr_bits+1)'(p_depth);

  logic [p_depth-1:0]    tag_q, tag_d;
  logic [p_ptr_bits-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [p_ptr_bits:0]   count_q, count_d;
  logic                  resp_err_q, resp_err_d;

  logic full, any_val, gnt_dmem, enq, deq, spurious, head_tag;

  // Full gating uses only the registered count, so memreq_rdy never
  // reaches memreq_val combinationally.
  assign full     = (count_q == DEPTH_C);
  assign any_val  = imemreq_val | dmemreq_val;

`ifdef PARC_MEM_ARB_RR_EN
  logic last_dmem_q, last_dmem_d;

  // Contention goes to whichever port lost the last accepted transfer.
  always_comb begin
    gnt_dmem = dmemreq_val | ~imemreq_val;
    if (dmemreq_val && imemreq_val) gnt_dmem = ~last_dmem_q;
  end

  // Remember who won, but only when a transfer actually happened.
  always_comb begin
    last_dmem_d = last_dmem_q;
    if (enq) last_dmem_d = gnt_dmem;
  end

  // Reset to 0 so the first contention goes to dmem.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_dmem_q <= 1'b0;
    else        last_dmem_q <= last_dmem_d;
  end
`else
  // Fixed priority; with nothing valid the select rests on dmem.
  assign gnt_dmem = dmemreq_val | ~imemreq_val;
`endif

  // Request side: outputs forced low while reset is held.
  assign memreq_val  = reset & any_val & ~full;
  assign memreq_msg  = gnt_dmem ? dmemreq_msg : imemreq_msg;
  assign dmemreq_rdy = memreq_val & memreq_rdy & gnt_dmem;
  assign imemreq_rdy = memreq_val & memreq_rdy & ~gnt_dmem;
  assign enq         = memreq_val & memreq_rdy;

  // Response side: zero-latency steering by the head tag.
  assign head_tag     = tag_q[rd_ptr_q];
  assign deq          = reset & memresp_val & (count_q != '0);
  assign spurious     = reset & memresp_val & (count_q == '0);
  assign dmemresp_val = deq & head_tag;
  assign imemresp_val = deq & ~head_tag;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_msg = memresp_msg;
  assign resp_err     = resp_err_q;

  // Tag FIFO next state; pointers wrap naturally at p_depth.
  always_comb begin
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    resp_err_d = resp_err_q | spurious;
    if (enq) begin
      tag_d[wr_ptr_q] = gnt_dmem;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + (p_ptr_bits+1)'(1);
      2'b01:   count_d = count_q - (p_ptr_bits+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every outstanding tag and the error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule
